// File: rtl/fpmul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fpmul_rr_scheduler
//
// Purpose: shares one external FP32 multiplier among NUM_REQ requesters.
// A round-robin arbiter grants at most one requester per cycle. The granted
// operands are registered onto the multiplier inputs. The id of each issued
// operation travels down a tag pipeline that matches the multiplier latency,
// so the returning product is registered and tagged with its owner.
//
// Optional feature: define FPMUL_RR_SCHED_STATS_EN to build saturating
// 16-bit per-requester grant counters. Without it, grant_cnt is tied to zero.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            1 allows new grants; 0 stops granting while in-flight ops drain
//   req_valid     per-requester request
//   req_a, req_b  packed operands, slice i belongs to requester i
//   req_ready     one-hot grant, or all zero
//   mul_a, mul_b  registered operands to the multiplier
//   mul_valid     mul_a/mul_b carry a new operation this cycle
//   mul_result    multiplier product, MUL_LAT cycles after mul_a/mul_b
//   rsp_valid     rsp_id/rsp_data are valid for this cycle only
//   rsp_id        index of the requester that owns rsp_data
//   rsp_data      registered product
//   busy          at least one operation is in flight
//   grant_cnt     per-requester grant counters, 16 bits each
// ---------------------------------------------------------------------------
module fpmul_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 32,
    parameter int MUL_LAT   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BIT_WIDTH-1:0]         mul_a,
    output logic [BIT_WIDTH-1:0]         mul_b,
    output logic                         mul_valid,
    input  logic [BIT_WIDTH-1:0]         mul_result,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [BIT_WIDTH-1:0]         rsp_data,
    output logic                         busy,
    output logic [NUM_REQ*16-1:0]        grant_cnt
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]                rrPtr_q, rrPtr_d;
    logic [IDW-1:0]                grantIdx;
    logic [IDW-1:0]                scanIdx;
    logic                          grantFound;
    logic                          handshake;
    logic [BIT_WIDTH-1:0]          selA, selB;

    logic [BIT_WIDTH-1:0]          mulA_q, mulA_d;
    logic [BIT_WIDTH-1:0]          mulB_q, mulB_d;
    logic                          mulValid_q, mulValid_d;

    logic [MUL_LAT:0]              tagValid_q, tagValid_d;
    logic [MUL_LAT:0][IDW-1:0]     tagId_q, tagId_d;

    logic                          rspValid_q, rspValid_d;
    logic [IDW-1:0]                rspId_q, rspId_d;
    logic [BIT_WIDTH-1:0]          rspData_q, rspData_d;
    logic                          busy_q, busy_d;

    // Round-robin search: the first asserted request at or after rrPtr_q.
    // NUM_REQ is a power of two, so the IDW-bit sum wraps modulo NUM_REQ.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanIdx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = rrPtr_q + IDW'(k);
            if (!grantFound && req_valid[scanIdx]) begin
                grantFound = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    // The grant is suppressed during reset and while en is low, which also
    // freezes the pointer because no handshake can occur.
    assign req_ready = (en && !rst && grantFound) ? (NUM_REQ'(1) << grantIdx) : '0;
    assign handshake = |(req_valid & req_ready);

    // Select the operands of the winning requester.
    always_comb begin
        selA = '0;
        selB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                selA = req_a[i*BIT_WIDTH +: BIT_WIDTH];
                selB = req_b[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Next-state logic. The multiplier operands only change on a handshake.
    // This keeps the multiplier inputs quiet on idle cycles. Tag stage j
    // describes the operation whose product appears on mul_result j cycles
    // after issue. The last stage therefore marks the cycle in which
    // mul_result is captured.
    always_comb begin
        rrPtr_d    = rrPtr_q;
        mulA_d     = mulA_q;
        mulB_d     = mulB_q;
        mulValid_d = handshake;
        if (handshake) begin
            rrPtr_d = grantIdx + IDW'(1);
            mulA_d  = selA;
            mulB_d  = selB;
        end

        tagValid_d    = '0;
        tagId_d       = '0;
        tagValid_d[0] = handshake;
        tagId_d[0]    = grantIdx;
        for (int j = 1; j <= MUL_LAT; j++) begin
            tagValid_d[j] = tagValid_q[j-1];
            tagId_d[j]    = tagId_q[j-1];
        end

        rspValid_d = tagValid_q[MUL_LAT];
        rspId_d    = tagValid_q[MUL_LAT] ? tagId_q[MUL_LAT] : rspId_q;
        rspData_d  = tagValid_q[MUL_LAT] ? mul_result : rspData_q;

        // Busy next cycle covers a new issue and any op still in the tags.
        // The op in the last tag becomes the response, so busy stays high
        // through the final rsp_valid cycle.
        busy_d = handshake | (|tagValid_q);
    end

    // State registers. Reset discards every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q    <= '0;
            mulA_q     <= '0;
            mulB_q     <= '0;
            mulValid_q <= 1'b0;
            tagValid_q <= '0;
            tagId_q    <= '0;
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspData_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            mulA_q     <= mulA_d;
            mulB_q     <= mulB_d;
            mulValid_q <= mulValid_d;
            tagValid_q <= tagValid_d;
            tagId_q    <= tagId_d;
            rspValid_q <= rspValid_d;
            rspId_q    <= rspId_d;
            rspData_q  <= rspData_d;
            busy_q     <= busy_d;
        end
    end

    assign mul_a     = mulA_q;
    assign mul_b     = mulB_q;
    assign mul_valid = mulValid_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign busy      = busy_q;

`ifdef FPMUL_RR_SCHED_STATS_EN
    logic [NUM_REQ-1:0][15:0] grantCnt_q, grantCnt_d;

    // Saturating grant counters, one per requester.
    always_comb begin
        grantCnt_d = grantCnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && grantCnt_q[i] != 16'hFFFF) begin
                grantCnt_d[i] = grantCnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grantCnt_q <= '0;
        end else begin
            grantCnt_q <= grantCnt_d;
        end
    end

    assign grant_cnt = grantCnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule
